// File: rtl/queue_pkg.sv
// Shared definitions for both sides of the RAM-backed byte queue.
// Pointers carry one extra wrap bit above the RAM address.
package queue_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/queue_out_buf.sv
// Two-entry registered FIFO between the RAM read port and the consumer.
// Entry 0 is always the head, so the output is a plain register with no mux.
module queue_out_buf #(
    parameter int DATA_W = queue_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_entry0;
    logic [DATA_W-1:0] r_entry1;
    logic [1:0]        r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_occ    <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_entry0 <= i_push_data;
                    end else begin
                        r_entry1 <= i_push_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_occ    <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves while the new word joins: occupancy holds, order is kept.
                    if (r_occ == 2'd1) begin
                        r_entry0 <= i_push_data;
                    end else begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head = r_entry0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/queue_reader.sv
// Dequeue side of the RAM-backed queue: read pointer, RAM read issue (yielding
// to the writer) and a 2-entry prefetch buffer on a valid/ready output.
module queue_reader #(
    parameter int ADDR_W = queue_pkg::ADDR_W,
    parameter int DATA_W = queue_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic              wr_req,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_sel,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              empty
);

    // Handshake: a word transfers in every cycle where out_valid and out_ready
    // are both high; out_data holds while out_valid is high and out_ready is low.

    logic [ADDR_W:0] r_rd_ptr;
    logic            r_inflight;
    logic [1:0]      w_occ;
    logic [1:0]      w_pending;
    logic            w_ram_empty;
    logic            w_pop;
    logic            w_issue;

    assign w_ram_empty = (r_rd_ptr == wr_ptr);
    assign w_pop       = out_valid & out_ready;
    assign w_pending   = w_occ + {1'b0, r_inflight};

    // A pop frees a slot this cycle, so a full pipeline may still issue.
    assign w_issue = rst_n & !w_ram_empty & !wr_req & ((w_pending < 2'd2) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_inflight <= w_issue;
        end
    end

    queue_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (ram_rdata),
        .i_pop       (w_pop),
        .o_head      (out_data),
        .o_occ       (w_occ)
    );

    assign rd_ptr    = r_rd_ptr;
    assign ram_addr  = r_rd_ptr[ADDR_W-1:0];
    assign ram_sel   = w_issue;
    assign out_valid = (w_occ != 2'd0);
    assign empty     = w_ram_empty & !r_inflight & (w_occ == 2'd0);

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: behavioural single-port RAM, cycle table for the
// basic drain, and a scoreboard queue checked on every output transfer.
module tb_queue_reader;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [AW:0]   wr_ptr;
    logic          wr_req;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] ram_addr;
    logic          ram_sel;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          empty;

    logic [DW-1:0] ram [1024];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];
    logic          addr_log_en;

    int n_vec;
    int n_miss;

    queue_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_ptr    (wr_ptr),
        .wr_req    (wr_req),
        .rd_ptr    (rd_ptr),
        .ram_addr  (ram_addr),
        .ram_sel   (ram_sel),
        .ram_rdata (ram_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_sel) ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted output word must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
                check("sb_out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (wr_req) check("sel_during_wr_req", {31'd0, ram_sel}, 32'd0);
        if (ram_sel && addr_log_en) addr_q.push_back(ram_addr);
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        wr_ptr    = '0;
        wr_req    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic preload_a();
        for (int i = 0; i < 4; i++) ram[i] = 8'hA0 + 8'(i);
    endtask

    task automatic push_a();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    endtask

    typedef struct {
        logic       wr_req;
        logic       out_ready;
        logic       exp_sel;
        logic       exp_valid;
        logic       chk_data;
        logic [7:0] exp_data;
        logic       exp_empty;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int sel_cnt;
        int cyc;
        n_vec       = 0;
        n_miss      = 0;
        addr_log_en = 1'b0;
        ram_rdata   = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'h5A;

        //                 wr_req ready sel valid chk data   empty
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

        // Reset state held for 10 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_empty", {31'd0, empty}, 32'd1);
            check("rst_valid", {31'd0, out_valid}, 32'd0);
            check("rst_sel", {31'd0, ram_sel}, 32'd0);
            check("rst_rd_ptr", {21'd0, rd_ptr}, 32'd0);
        end
        check("rst_out_data", {24'd0, out_data}, 32'd0);

        // Streaming drain, cycle table.
        do_reset();
        preload_a();
        push_a();
        @(posedge clk); #1;
        wr_ptr = 11'd4;
        for (int i = 0; i < 7; i++) begin
            wr_req    = vecs[i].wr_req;
            out_ready = vecs[i].out_ready;
            @(negedge clk);
            check($sformatf("tbl%0d_sel", i), {31'd0, ram_sel}, {31'd0, vecs[i].exp_sel});
            check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_empty});
            if (vecs[i].chk_data)
                check($sformatf("tbl%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].exp_data});
            @(posedge clk); #1;
        end
        check("drain_sb_empty", exp_q.size(), 0);

        // Backpressure: two reads then stall with a stable head.
        do_reset();
        push_a();
        sel_cnt = 0;
        @(posedge clk); #1;
        wr_ptr = 11'd4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ram_sel) sel_cnt++;
            if (i >= 2) check("bp_head_stable", {24'd0, out_data}, 32'hA0);
            @(posedge clk); #1;
        end
        check("bp_reads", sel_cnt, 2);
        check("bp_rd_ptr", {21'd0, rd_ptr}, 32'd2);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_release_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_final_empty", {31'd0, empty}, 32'd1);
        check("bp_sb_empty", exp_q.size(), 0);

        // Writer contention on alternate cycles.
        @(posedge clk); #1;
        do_reset();
        push_a();
        out_ready = 1'b1;
        @(posedge clk); #1;
        wr_ptr = 11'd4;
        for (int i = 0; i < 16; i++) begin
            wr_req = (i % 2 == 0);
            @(posedge clk); #1;
        end
        wr_req = 1'b0;
        @(negedge clk);
        check("wrreq_empty", {31'd0, empty}, 32'd1);
        check("wrreq_sb_empty", exp_q.size(), 0);

        // Random contention and backpressure over a longer run.
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            ram[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(ram[i]);
        end
        @(posedge clk); #1;
        wr_ptr = 11'd40;
        cyc = 0;
        while (!(empty && exp_q.size() == 0) && cyc < 600) begin
            wr_req    = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        wr_req = 1'b0;
        check("rand_done", {31'd0, (cyc < 600)}, 32'd1);
        check("rand_rd_ptr", {21'd0, rd_ptr}, 32'd40);

        // Pointer wrap: advance to 1022, then read across the address wrap.
        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 1022; i++) exp_q.push_back(8'(i) ^ 8'h5A);
        out_ready = 1'b1;
        @(posedge clk); #1;
        wr_ptr = 11'd1022;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!empty && cyc < 1500);
        check("wrap_pre_empty", {31'd0, empty}, 32'd1);
        check("wrap_pre_rd_ptr", {21'd0, rd_ptr}, 32'd1022);
        @(posedge clk); #1;
        addr_q.delete();
        addr_log_en = 1'b1;
        exp_q.push_back(8'(1022) ^ 8'h5A);
        exp_q.push_back(8'(1023) ^ 8'h5A);
        exp_q.push_back(8'h00 ^ 8'h5A);
        exp_q.push_back(8'h01 ^ 8'h5A);
        wr_ptr = 11'h402;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!empty && cyc < 50);
        addr_log_en = 1'b0;
        check("wrap_empty", {31'd0, empty}, 32'd1);
        check("wrap_rd_ptr", {21'd0, rd_ptr}, 32'h402);
        check("wrap_n_addr", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
            check("wrap_addr0", {22'd0, addr_q[0]}, 32'd1022);
            check("wrap_addr1", {22'd0, addr_q[1]}, 32'd1023);
            check("wrap_addr2", {22'd0, addr_q[2]}, 32'd0);
            check("wrap_addr3", {22'd0, addr_q[3]}, 32'd1);
        end
        check("wrap_sb_empty", exp_q.size(), 0);

        // Asynchronous reset with a read outstanding and one word buffered.
        @(posedge clk); #1;
        do_reset();
        preload_a();
        @(posedge clk); #1;
        wr_ptr = 11'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_rd_ptr", {21'd0, rd_ptr}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_sel", {31'd0, ram_sel}, 32'd0);
        check("arst_data", {24'd0, out_data}, 32'd0);
        wr_ptr = 11'd0;
        #1;
        check("arst_empty", {31'd0, empty}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arst_post_valid", {31'd0, out_valid}, 32'd0);
            check("arst_post_empty", {31'd0, empty}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
